// File: rtl/tlb_op_ctrl_pkg.sv
// ============================================================================
// Module      : tlb_op_ctrl_pkg
// Description : Shared op encodings, FSM states and constants for the
//               TLB-maintenance sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlb_op_ctrl_pkg;

  // Bit positions inside the one-hot op vector {tlbwr,tlbwi,tlbr,tlbp}
  localparam int OP_TLBP  = 0;
  localparam int OP_TLBR  = 1;
  localparam int OP_TLBWI = 2;
  localparam int OP_TLBWR = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_COMMIT = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  localparam logic [31:0] PROBE_MISS = 32'h8000_0000;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tlb_op_snapshot.sv
// ============================================================================
// Module      : tlb_op_snapshot
// Description : CP0 snapshot registers feeding the TLB request, plus the
//               registered probe/read results returned to CP0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_op_snapshot
  import tlb_op_ctrl_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_i,
  input  logic [3:0]       op_i,
  input  logic [31:0]      cp0_index_i,
  input  logic [31:0]      cp0_random_i,
  input  logic [31:0]      cp0_entry_hi_i,
  input  logic [31:0]      cp0_entry_lo0_i,
  input  logic [31:0]      cp0_entry_lo1_i,
  input  logic [31:0]      cp0_page_mask_i,
  input  logic             rsp_valid_i,
  input  logic             hit_i,
  input  logic [IDX_W-1:0] hit_idx_i,
  input  logic [31:0]      rdata_hi_i,
  input  logic [31:0]      rdata_lo0_i,
  input  logic [31:0]      rdata_lo1_i,
  input  logic [31:0]      rdata_mask_i,
  output logic [3:0]       op_o,
  output logic             tlb_we_o,
  output logic             tlb_probe_o,
  output logic [IDX_W-1:0] tlb_idx_o,
  output logic [31:0]      tlb_entry_hi_o,
  output logic [31:0]      tlb_entry_lo0_o,
  output logic [31:0]      tlb_entry_lo1_o,
  output logic [31:0]      tlb_page_mask_o,
  output logic [31:0]      index_o,
  output logic [31:0]      entry_hi_o,
  output logic [31:0]      entry_lo0_o,
  output logic [31:0]      entry_lo1_o,
  output logic [31:0]      page_mask_o
);

  logic [3:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_sel;
  logic [31:0]      key_hi_q, key_hi_d, key_lo0_q, key_lo0_d;
  logic [31:0]      key_lo1_q, key_lo1_d, key_mask_q, key_mask_d;
  logic [31:0]      index_q, index_d, res_hi_q, res_hi_d;
  logic [31:0]      res_lo0_q, res_lo0_d, res_lo1_q, res_lo1_d;
  logic [31:0]      res_mask_q, res_mask_d;
  logic             unused_upper_bits;

  // Only the low IDX_W bits address the array; selection wraps modulo size
  assign unused_upper_bits = ^{cp0_index_i[31:IDX_W], cp0_random_i[31:IDX_W]};

  always_comb begin
    idx_sel = '0;
    if (op_i[OP_TLBWR])
      idx_sel = cp0_random_i[IDX_W-1:0];
    else if (op_i[OP_TLBWI] || op_i[OP_TLBR])
      idx_sel = cp0_index_i[IDX_W-1:0];
  end

  always_comb begin
    op_d       = op_q;
    idx_d      = idx_q;
    key_hi_d   = key_hi_q;
    key_lo0_d  = key_lo0_q;
    key_lo1_d  = key_lo1_q;
    key_mask_d = key_mask_q;
    index_d    = index_q;
    res_hi_d   = res_hi_q;
    res_lo0_d  = res_lo0_q;
    res_lo1_d  = res_lo1_q;
    res_mask_d = res_mask_q;
    if (capture_i) begin
      op_d       = op_i;
      idx_d      = idx_sel;
      key_hi_d   = cp0_entry_hi_i;
      key_lo0_d  = cp0_entry_lo0_i;
      key_lo1_d  = cp0_entry_lo1_i;
      key_mask_d = cp0_page_mask_i;
    end
    if (rsp_valid_i) begin
      if (op_q[OP_TLBP]) begin
        index_d = hit_i ? {{(32-IDX_W){1'b0}}, hit_idx_i} : PROBE_MISS;
      end else begin
        res_hi_d   = rdata_hi_i;
        res_lo0_d  = rdata_lo0_i;
        res_lo1_d  = rdata_lo1_i;
        res_mask_d = rdata_mask_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      idx_q      <= '0;
      key_hi_q   <= '0;
      key_lo0_q  <= '0;
      key_lo1_q  <= '0;
      key_mask_q <= '0;
      index_q    <= '0;
      res_hi_q   <= '0;
      res_lo0_q  <= '0;
      res_lo1_q  <= '0;
      res_mask_q <= '0;
    end else begin
      op_q       <= op_d;
      idx_q      <= idx_d;
      key_hi_q   <= key_hi_d;
      key_lo0_q  <= key_lo0_d;
      key_lo1_q  <= key_lo1_d;
      key_mask_q <= key_mask_d;
      index_q    <= index_d;
      res_hi_q   <= res_hi_d;
      res_lo0_q  <= res_lo0_d;
      res_lo1_q  <= res_lo1_d;
      res_mask_q <= res_mask_d;
    end
  end

  assign op_o            = op_q;
  assign tlb_we_o        = op_q[OP_TLBWI] | op_q[OP_TLBWR];
  assign tlb_probe_o     = op_q[OP_TLBP];
  assign tlb_idx_o       = idx_q;
  assign tlb_entry_hi_o  = key_hi_q;
  assign tlb_entry_lo0_o = key_lo0_q;
  assign tlb_entry_lo1_o = key_lo1_q;
  assign tlb_page_mask_o = key_mask_q;
  assign index_o         = index_q;
  assign entry_hi_o      = res_hi_q;
  assign entry_lo0_o     = res_lo0_q;
  assign entry_lo1_o     = res_lo1_q;
  assign page_mask_o     = res_mask_q;

endmodule

`default_nettype wire

// File: rtl/tlb_op_ctrl.sv
// ============================================================================
// Module      : tlb_op_ctrl
// Description : Multi-cycle sequencer for TLBP/TLBR/TLBWI/TLBWR between CP0
//               and the shared TLB array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLB_LINE_NUM = 16,
  parameter int IDX_W        = $clog2(TLB_LINE_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid_i,
  input  logic [3:0]       op_type_i,
  input  logic             flush_exception_i,
  input  logic             stall_other_i,
  input  logic [31:0]      cp0_index_i,
  input  logic [31:0]      cp0_random_i,
  input  logic [31:0]      cp0_entry_hi_i,
  input  logic [31:0]      cp0_entry_lo0_i,
  input  logic [31:0]      cp0_entry_lo1_i,
  input  logic [31:0]      cp0_page_mask_i,
  output logic             tlb_req_o,
  output logic             tlb_we_o,
  output logic             tlb_probe_o,
  output logic [IDX_W-1:0] tlb_idx_o,
  output logic [31:0]      tlb_entry_hi_o,
  output logic [31:0]      tlb_entry_lo0_o,
  output logic [31:0]      tlb_entry_lo1_o,
  output logic [31:0]      tlb_page_mask_o,
  input  logic             tlb_ready_i,
  input  logic             tlb_rvalid_i,
  input  logic             tlb_hit_i,
  input  logic [IDX_W-1:0] tlb_hit_idx_i,
  input  logic [31:0]      tlb_rdata_hi_i,
  input  logic [31:0]      tlb_rdata_lo0_i,
  input  logic [31:0]      tlb_rdata_lo1_i,
  input  logic [31:0]      tlb_rdata_mask_i,
  output logic [3:0]       tlb_type_o,
  output logic [31:0]      index_o,
  output logic [31:0]      entry_hi_o,
  output logic [31:0]      entry_lo0_o,
  output logic [31:0]      entry_lo1_o,
  output logic [31:0]      page_mask_o,
  output logic             utlb_flush_o,
  output logic             stall_o,
  output logic             busy_o
);

  logic [2:0] state_q, state_d;
  logic       abort_q, abort_d;
  logic       accept;
  logic       rsp_valid;
  logic       is_write;
  logic [3:0] op_q;

  assign accept = ~rst & (state_q == ST_IDLE) & op_valid_i & ~flush_exception_i
                & is_onehot4(op_type_i);
  assign rsp_valid = (state_q == ST_WAIT) & tlb_rvalid_i;
  assign is_write  = op_q[OP_TLBWI] | op_q[OP_TLBWR];

  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (flush_exception_i) abort_d = 1'b1;
        if (tlb_ready_i) state_d = is_write ? ST_COMMIT : ST_WAIT;
      end
      ST_WAIT: begin
        if (flush_exception_i) abort_d = 1'b1;
        if (tlb_rvalid_i) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = stall_other_i ? ST_HOLD : ST_IDLE;
      ST_HOLD:   if (!stall_other_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  // A write already landed in the array, so it still reports even if aborted
  always_comb begin
    tlb_type_o = 4'b0000;
    if ((state_q == ST_COMMIT) && (is_write || !abort_q))
      tlb_type_o = op_q;
  end

  assign tlb_req_o    = (state_q == ST_ISSUE);
  assign utlb_flush_o = (state_q == ST_COMMIT) & is_write;
  assign stall_o      = accept | (state_q == ST_ISSUE) | (state_q == ST_WAIT);
  assign busy_o       = (state_q != ST_IDLE);

  tlb_op_snapshot #(
    .IDX_W (IDX_W)
  ) u_snapshot (
    .clk             (clk),
    .rst             (rst),
    .capture_i       (accept),
    .op_i            (op_type_i),
    .cp0_index_i     (cp0_index_i),
    .cp0_random_i    (cp0_random_i),
    .cp0_entry_hi_i  (cp0_entry_hi_i),
    .cp0_entry_lo0_i (cp0_entry_lo0_i),
    .cp0_entry_lo1_i (cp0_entry_lo1_i),
    .cp0_page_mask_i (cp0_page_mask_i),
    .rsp_valid_i     (rsp_valid),
    .hit_i           (tlb_hit_i),
    .hit_idx_i       (tlb_hit_idx_i),
    .rdata_hi_i      (tlb_rdata_hi_i),
    .rdata_lo0_i     (tlb_rdata_lo0_i),
    .rdata_lo1_i     (tlb_rdata_lo1_i),
    .rdata_mask_i    (tlb_rdata_mask_i),
    .op_o            (op_q),
    .tlb_we_o        (tlb_we_o),
    .tlb_probe_o     (tlb_probe_o),
    .tlb_idx_o       (tlb_idx_o),
    .tlb_entry_hi_o  (tlb_entry_hi_o),
    .tlb_entry_lo0_o (tlb_entry_lo0_o),
    .tlb_entry_lo1_o (tlb_entry_lo1_o),
    .tlb_page_mask_o (tlb_page_mask_o),
    .index_o         (index_o),
    .entry_hi_o      (entry_hi_o),
    .entry_lo0_o     (entry_lo0_o),
    .entry_lo1_o     (entry_lo1_o),
    .page_mask_o     (page_mask_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_tlb_op_ctrl.sv
// ============================================================================
// Module      : tb_tlb_op_ctrl
// Description : Directed self-checking bench for tlb_op_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid_i;
  logic [3:0]  op_type_i;
  logic        flush_exception_i;
  logic        stall_other_i;
  logic [31:0] cp0_index_i, cp0_random_i, cp0_entry_hi_i;
  logic [31:0] cp0_entry_lo0_i, cp0_entry_lo1_i, cp0_page_mask_i;
  logic        tlb_req_o, tlb_we_o, tlb_probe_o;
  logic [3:0]  tlb_idx_o;
  logic [31:0] tlb_entry_hi_o, tlb_entry_lo0_o, tlb_entry_lo1_o, tlb_page_mask_o;
  logic        tlb_ready_i, tlb_rvalid_i, tlb_hit_i;
  logic [3:0]  tlb_hit_idx_i;
  logic [31:0] tlb_rdata_hi_i, tlb_rdata_lo0_i, tlb_rdata_lo1_i, tlb_rdata_mask_i;
  logic [3:0]  tlb_type_o;
  logic [31:0] index_o, entry_hi_o, entry_lo0_o, entry_lo1_o, page_mask_o;
  logic        utlb_flush_o, stall_o, busy_o;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int p0;

  tlb_op_ctrl #(.TLB_LINE_NUM(16), .IDX_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .op_valid_i        (op_valid_i),
    .op_type_i         (op_type_i),
    .flush_exception_i (flush_exception_i),
    .stall_other_i     (stall_other_i),
    .cp0_index_i       (cp0_index_i),
    .cp0_random_i      (cp0_random_i),
    .cp0_entry_hi_i    (cp0_entry_hi_i),
    .cp0_entry_lo0_i   (cp0_entry_lo0_i),
    .cp0_entry_lo1_i   (cp0_entry_lo1_i),
    .cp0_page_mask_i   (cp0_page_mask_i),
    .tlb_req_o         (tlb_req_o),
    .tlb_we_o          (tlb_we_o),
    .tlb_probe_o       (tlb_probe_o),
    .tlb_idx_o         (tlb_idx_o),
    .tlb_entry_hi_o    (tlb_entry_hi_o),
    .tlb_entry_lo0_o   (tlb_entry_lo0_o),
    .tlb_entry_lo1_o   (tlb_entry_lo1_o),
    .tlb_page_mask_o   (tlb_page_mask_o),
    .tlb_ready_i       (tlb_ready_i),
    .tlb_rvalid_i      (tlb_rvalid_i),
    .tlb_hit_i         (tlb_hit_i),
    .tlb_hit_idx_i     (tlb_hit_idx_i),
    .tlb_rdata_hi_i    (tlb_rdata_hi_i),
    .tlb_rdata_lo0_i   (tlb_rdata_lo0_i),
    .tlb_rdata_lo1_i   (tlb_rdata_lo1_i),
    .tlb_rdata_mask_i  (tlb_rdata_mask_i),
    .tlb_type_o        (tlb_type_o),
    .index_o           (index_o),
    .entry_hi_o        (entry_hi_o),
    .entry_lo0_o       (entry_lo0_o),
    .entry_lo1_o       (entry_lo1_o),
    .page_mask_o       (page_mask_o),
    .utlb_flush_o      (utlb_flush_o),
    .stall_o           (stall_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tlb_type_o != 4'b0000) pulse_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    op_valid_i = 1'b0; op_type_i = 4'b0000;
    flush_exception_i = 1'b0; stall_other_i = 1'b0;
    cp0_index_i = '0; cp0_random_i = '0; cp0_entry_hi_i = '0;
    cp0_entry_lo0_i = '0; cp0_entry_lo1_i = '0; cp0_page_mask_i = '0;
    tlb_ready_i = 1'b0; tlb_rvalid_i = 1'b0; tlb_hit_i = 1'b0; tlb_hit_idx_i = '0;
    tlb_rdata_hi_i = '0; tlb_rdata_lo0_i = '0; tlb_rdata_lo1_i = '0; tlb_rdata_mask_i = '0;
    tick(); tick();

    // Reset state
    #1;
    chk("rst_req", tlb_req_o, 0);
    chk("rst_type", tlb_type_o, 0);
    chk("rst_flush", utlb_flush_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_index", index_o, 0);
    chk("rst_idx", tlb_idx_o, 0);
    rst = 1'b0;
    tick();

    // 1: tlbwi index 5, ready held high
    op_valid_i = 1'b1; op_type_i = 4'b0100; cp0_index_i = 32'd5;
    cp0_entry_hi_i = 32'hAAAA_0000; tlb_ready_i = 1'b1;
    #1;
    chk("t1_acc_stall", stall_o, 1);
    chk("t1_acc_req", tlb_req_o, 0);
    tick();
    chk("t1_iss_req", tlb_req_o, 1);
    chk("t1_iss_we", tlb_we_o, 1);
    chk("t1_iss_probe", tlb_probe_o, 0);
    chk("t1_iss_idx", tlb_idx_o, 5);
    chk("t1_iss_hi", tlb_entry_hi_o, 32'hAAAA_0000);
    chk("t1_iss_stall", stall_o, 1);
    tick();
    chk("t1_com_type", tlb_type_o, 4'b0100);
    chk("t1_com_flush", utlb_flush_o, 1);
    chk("t1_com_stall", stall_o, 0);
    chk("t1_com_req", tlb_req_o, 0);
    op_valid_i = 1'b0; tlb_ready_i = 1'b0;
    tick();
    chk("t1_idle_busy", busy_o, 0);
    chk("t1_idle_type", tlb_type_o, 0);

    // 2a: tlbp, ready after 3 cycles, hit at 9; CP0 changes must not leak
    op_valid_i = 1'b1; op_type_i = 4'b0001; cp0_entry_hi_i = 32'h1234_5000;
    tick();
    cp0_entry_hi_i = 32'hDEAD_0000;
    for (int i = 0; i < 4; i++) begin
      tlb_ready_i = (i == 3);
      #1;
      chk("t2_iss_req", tlb_req_o, 1);
      chk("t2_iss_probe", tlb_probe_o, 1);
      chk("t2_iss_we", tlb_we_o, 0);
      chk("t2_iss_idx", tlb_idx_o, 0);
      chk("t2_iss_hi", tlb_entry_hi_o, 32'h1234_5000);
      tick();
    end
    tlb_ready_i = 1'b0; tlb_rvalid_i = 1'b1; tlb_hit_i = 1'b1; tlb_hit_idx_i = 4'd9;
    #1;
    chk("t2_wait_req", tlb_req_o, 0);
    chk("t2_wait_stall", stall_o, 1);
    tick();
    tlb_rvalid_i = 1'b0; op_valid_i = 1'b0;
    chk("t2_com_type", tlb_type_o, 4'b0001);
    chk("t2_com_index", index_o, 32'h0000_0009);
    chk("t2_com_flush", utlb_flush_o, 0);
    tick();

    // 2b: tlbp miss
    op_valid_i = 1'b1; op_type_i = 4'b0001; tlb_ready_i = 1'b1;
    tick();
    tick();
    tlb_ready_i = 1'b0; tlb_rvalid_i = 1'b1; tlb_hit_i = 1'b0;
    tick();
    tlb_rvalid_i = 1'b0; op_valid_i = 1'b0;
    chk("t2m_com_type", tlb_type_o, 4'b0001);
    chk("t2m_com_index", index_o, 32'h8000_0000);
    chk("t2m_com_hi", entry_hi_o, 32'h0);
    tick();

    // 3: tlbr with index wrap 0x13 -> 3
    op_valid_i = 1'b1; op_type_i = 4'b0010; cp0_index_i = 32'h0000_0013; tlb_ready_i = 1'b1;
    tick();
    chk("t3_iss_idx", tlb_idx_o, 3);
    chk("t3_iss_we", tlb_we_o, 0);
    tick();
    tlb_ready_i = 1'b0;
    #1;
    chk("t3_wait_stall", stall_o, 1);
    tick();
    tlb_rvalid_i = 1'b1;
    tlb_rdata_hi_i = 32'h1111_1111; tlb_rdata_lo0_i = 32'h2222_2222;
    tlb_rdata_lo1_i = 32'h3333_3333; tlb_rdata_mask_i = 32'h0000_6000;
    tick();
    tlb_rvalid_i = 1'b0; op_valid_i = 1'b0;
    chk("t3_com_type", tlb_type_o, 4'b0010);
    chk("t3_com_hi", entry_hi_o, 32'h1111_1111);
    chk("t3_com_lo0", entry_lo0_o, 32'h2222_2222);
    chk("t3_com_lo1", entry_lo1_o, 32'h3333_3333);
    chk("t3_com_mask", page_mask_o, 32'h0000_6000);
    chk("t3_com_index", index_o, 32'h8000_0000);
    tick();

    // 4: tlbwr random 12 with stall_other around COMMIT
    p0 = pulse_cnt;
    op_valid_i = 1'b1; op_type_i = 4'b1000; cp0_random_i = 32'h0000_000C; tlb_ready_i = 1'b1;
    tick();
    stall_other_i = 1'b1;
    #1;
    chk("t4_iss_idx", tlb_idx_o, 4'hC);
    chk("t4_iss_we", tlb_we_o, 1);
    tick();
    tlb_ready_i = 1'b0;
    chk("t4_com_type", tlb_type_o, 4'b1000);
    chk("t4_com_flush", utlb_flush_o, 1);
    tick();
    chk("t4_hold_type", tlb_type_o, 0);
    chk("t4_hold_stall", stall_o, 0);
    chk("t4_hold_busy", busy_o, 1);
    tick();
    stall_other_i = 1'b0;
    #1;
    chk("t4_hold2_busy", busy_o, 1);
    chk("t4_hold2_req", tlb_req_o, 0);
    tick();
    op_valid_i = 1'b0;
    #1;
    chk("t4_idle_busy", busy_o, 0);
    tick();
    chk("t4_pulses", pulse_cnt - p0, 1);

    // 5: tlbr aborted in WAIT, then a multi-hot op, then a normal tlbwi
    op_valid_i = 1'b1; op_type_i = 4'b0010; tlb_ready_i = 1'b1;
    tick();
    tick();
    tlb_ready_i = 1'b0; flush_exception_i = 1'b1;
    tick();
    flush_exception_i = 1'b0; tlb_rvalid_i = 1'b1;
    #1;
    chk("t5_wait_busy", busy_o, 1);
    chk("t5_wait_req", tlb_req_o, 0);
    tick();
    tlb_rvalid_i = 1'b0; op_valid_i = 1'b0;
    chk("t5_com_type", tlb_type_o, 0);
    chk("t5_com_busy", busy_o, 1);
    chk("t5_com_stall", stall_o, 0);
    tick();
    op_valid_i = 1'b1; op_type_i = 4'b0110;
    #1;
    chk("t5_multi_stall", stall_o, 0);
    tick();
    chk("t5_multi_busy", busy_o, 0);
    op_type_i = 4'b0100; cp0_index_i = 32'd7; tlb_ready_i = 1'b1;
    #1;
    chk("t5_acc_stall", stall_o, 1);
    tick();
    chk("t5_iss_idx", tlb_idx_o, 7);
    tick();
    chk("t5_com_type2", tlb_type_o, 4'b0100);
    op_valid_i = 1'b0; tlb_ready_i = 1'b0;
    tick();

    // 6: reset while in WAIT; late rvalid ignored
    op_valid_i = 1'b1; op_type_i = 4'b0010; tlb_ready_i = 1'b1;
    tick();
    tick();
    tlb_ready_i = 1'b0; rst = 1'b1;
    tick();
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_stall", stall_o, 0);
    chk("t6_rst_req", tlb_req_o, 0);
    chk("t6_rst_type", tlb_type_o, 0);
    chk("t6_rst_index", index_o, 0);
    chk("t6_rst_hi", entry_hi_o, 0);
    chk("t6_rst_idx", tlb_idx_o, 0);
    rst = 1'b0; op_valid_i = 1'b0; tlb_rvalid_i = 1'b1;
    tick();
    tlb_rvalid_i = 1'b0;
    chk("t6_late_busy", busy_o, 0);
    chk("t6_late_hi", entry_hi_o, 0);
    chk("t6_late_type", tlb_type_o, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
- Multi-cycle sequencer for the MIPS TLB-maintenance instructions TLBP, TLBR, TLBWI and TLBWR, issued from the MEM stage.
- Sits between the CP0 register file and the shared TLB array.
  - Snapshots Index/Random/EntryHi/EntryLo0/EntryLo1/PageMask from CP0.
  - Drives a valid/ready request to the TLB array and waits for any read/probe response.
  - Returns results to CP0 as a one-cycle tlb_type pulse plus data.
- Stalls the pipeline for the whole sequence and flushes the micro-TLBs after every write.

Parameters:
- TLB_LINE_NUM, 16, number of TLB entries.
- IDX_W, 4, index width; equals clog2(TLB_LINE_NUM).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- op_valid_i  in  1  TLB instruction present in MEM
- op_type_i  in  4  one-hot {tlbwr,tlbwi,tlbr,tlbp}
- flush_exception_i  in  1  pipeline exception flush
- stall_other_i  in  1  pipeline stalled by another source
- cp0_index_i, cp0_random_i, cp0_entry_hi_i, cp0_entry_lo0_i, cp0_entry_lo1_i, cp0_page_mask_i  in  32 each  current CP0 values
- tlb_req_o  out  1  request valid to TLB array
- tlb_we_o  out  1  1=write, 0=read/probe
- tlb_probe_o  out  1  request is a probe
- tlb_idx_o  out  IDX_W  target entry
- tlb_entry_hi_o, tlb_entry_lo0_o, tlb_entry_lo1_o, tlb_page_mask_o  out  32 each  write data / probe key
- tlb_ready_i  in  1  array accepts request
- tlb_rvalid_i  in  1  read/probe response valid
- tlb_hit_i  in  1  probe hit
- tlb_hit_idx_i  in  IDX_W  probe hit entry
- tlb_rdata_hi_i, tlb_rdata_lo0_i, tlb_rdata_lo1_i, tlb_rdata_mask_i  in  32 each  read data
- tlb_type_o  out  4  CP0 update pulse, {tlbwr,tlbwi,tlbr,tlbp}
- index_o, entry_hi_o, entry_lo0_o, entry_lo1_o, page_mask_o  out  32 each  CP0 update data
- utlb_flush_o  out  1  invalidate I/D micro-TLBs
- stall_o  out  1  hold pipeline at MEM
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - state=IDLE.
  - All outputs 0, including tlb_req_o, tlb_type_o, utlb_flush_o and stall_o.
  - All data registers 0.
  - Reset mid-sequence abandons the outstanding request immediately.
- Acceptance:
  - In IDLE, accept when op_valid_i & ~flush_exception_i & op_type_i is exactly one-hot.
  - Other op_type_i values (zero or multi-hot) are ignored; stay in IDLE with no stall.
  - On accept, latch the op and snapshot all CP0 inputs.
  - stall_o is asserted combinationally in that same cycle.
- Index selection:
  - tlbwi/tlbr: cp0_index_i[IDX_W-1:0].
  - tlbwr: cp0_random_i[IDX_W-1:0].
  - tlbp: 0.
  - Upper index bits are ignored, so selection wraps modulo TLB_LINE_NUM.
- States:
  - IDLE -> ISSUE on accept.
  - ISSUE:
    - tlb_req_o=1 with stable tlb_we_o/tlb_probe_o/tlb_idx_o/data until tlb_ready_i. Request must not drop or change before ready.
    - On ready, a write goes to COMMIT; a read or probe goes to WAIT.
  - WAIT:
    - tlb_req_o=0. On tlb_rvalid_i, capture the response and go to COMMIT.
    - tlb_rvalid_i in the same cycle as tlb_ready_i is not allowed; the response arrives at earliest the cycle after ready.
  - COMMIT (exactly 1 cycle):
    - tlb_type_o = latched one-hot op.
    - stall_o=0.
    - Writes: utlb_flush_o=1.
    - Go to HOLD if stall_other_i, else IDLE.
  - HOLD:
    - tlb_type_o=0, stall_o=0.
    - Wait until ~stall_other_i, then go to IDLE.
    - The still-present op_valid_i is never re-accepted, so no double commit.
- Minimum latency:
  - Write: accept -> commit = 2 cycles (ISSUE 1 cycle with ready=1).
  - Read/probe: 3 cycles.
- Probe result:
  - Hit: index_o = {1'b0, zeros, tlb_hit_idx_i}.
  - Miss: index_o = 32'h8000_0000.
  - Other outputs hold their previous values.
- Read result:
  - entry_hi_o, entry_lo0_o, entry_lo1_o and page_mask_o come from tlb_rdata_*.
  - index_o is unchanged.
- Output register timing: data outputs are registered and stable from COMMIT until the next capture.
- Flush after acceptance:
  - A handshake already in progress always completes; tlb_req_o never retracts.
  - flush_exception_i seen in ISSUE/WAIT sets the abort flag.
  - Aborted read/probe: tlb_type_o stays 0 in COMMIT.
  - Aborted write: the array write has happened, so the tlb_type_o pulse and utlb_flush_o are still issued.
  - Abort flag clears in IDLE.
- busy_o = (state != IDLE).

Decomposition:
- Shared package (defines header):
  - Op one-hot bit positions TLBP=0, TLBR=1, TLBWI=2, TLBWR=3.
  - State encodings.
  - PROBE_MISS = 32'h8000_0000.
- Sub-module: tlb_op_snapshot. Holds the CP0 snapshot registers and the result mux/registers.
- The FSM stays in tlb_op_ctrl.

Test Plan:
1. tlbwi, cp0_index=5, tlb_ready_i held 1 -> tlb_req_o/tlb_we_o/tlb_idx_o=5 for 1 cycle; COMMIT 2 cycles after accept with tlb_type_o=4'b0100 and utlb_flush_o=1; stall_o high exactly 2 cycles.
2. tlbp, ready delayed 3 cycles, rvalid with hit idx=9 -> request fields stable for 4 cycles; index_o=32'h0000_0009; tlb_type_o=4'b0001. Repeat with miss -> index_o=32'h8000_0000.
3. tlbr, cp0_index=32'h0000_0013 -> tlb_idx_o=3 (wrap); after rvalid, entry_lo0_o etc. equal the rdata; tlb_type_o=4'b0010.
4. tlbwr, random=12, stall_other_i=1 for 3 cycles around COMMIT -> exactly one tlb_type_o pulse (4'b1000); HOLD until release; no re-accept.
5. tlbr with flush_exception_i pulsed in WAIT -> handshake completes; tlb_type_o stays 0; next op accepted normally. op_type_i=4'b0110 -> ignored, no stall.
6. rst asserted in WAIT -> next cycle all outputs 0, state IDLE; late rvalid is ignored.
